// File: rtl/dev_bus_arbiter_pkg.sv
// Shared constants and helpers for the two-master device bus arbiter.
package dev_bus_arbiter_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Master indices (also the value carried on the owner output)
   localparam logic M_CPU = 1'b0;
   localparam logic M_DBG = 1'b1;

   // Device word-address bases as [31:4] values
   localparam logic [27:0] DEV_COUNTER_BASE = 28'h00007F0;
   localparam logic [27:0] DEV_SWITCH_BASE  = 28'h00007F1;
   localparam logic [27:0] DEV_DISPLAY_BASE = 28'h00007F2;

   // Two-way round-robin: a lone requester wins; on a tie the master
   // that did not own the bus last time wins.
   function automatic logic rr_pick(input logic cpu_req, input logic dbg_req,
                                    input logic last_owner);
      logic win;
      if (cpu_req && dbg_req) begin
         win = ~last_owner;
      end else if (dbg_req) begin
         win = M_DBG;
      end else begin
         win = M_CPU;
      end
      return win;
   endfunction

endpackage

// File: rtl/dev_bus_arbiter.sv
// Two-master arbiter sharing the device bridge port between the CPU MEM
// stage and the debug/loader master. Each access is latched, driven on the
// device bus for HOLD_CYCLES cycles with a single write strobe in the last
// cycle, and completed with a one-cycle ack carrying the captured read data.
module dev_bus_arbiter
   import dev_bus_arbiter_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter int unsigned CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic [29:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_be,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic [29:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic        dbg_we,
   input  logic [3:0]  dbg_be,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata,
   output logic [29:0] bus_addr,
   output logic [31:0] bus_dout,
   output logic [3:0]  bus_be,
   output logic        bus_we,
   input  logic [31:0] bus_din,
   output logic        busy,
   output logic        owner
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic [29:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic [31:0]       dbg_rdata_q, dbg_rdata_d;
   logic              win_s;

   assign win_s = rr_pick(cpu_req, dbg_req, owner_q);

   // State register: FSM, hold counter, latched access and read-data holders
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         owner_q     <= M_DBG;
         addr_q      <= 30'd0;
         wdata_q     <= 32'd0;
         we_q        <= 1'b0;
         be_q        <= 4'd0;
         cpu_rdata_q <= 32'd0;
         dbg_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         be_q        <= be_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, count down the hold, capture read data
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      be_d        = be_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_req || dbg_req) begin
               state_d = ST_ACCESS;
               owner_d = win_s;
               cnt_d   = CNT_LOAD;
               if (win_s == M_DBG) begin
                  addr_d  = dbg_addr;
                  wdata_d = dbg_wdata;
                  we_d    = dbg_we;
                  be_d    = dbg_be;
               end else begin
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
                  we_d    = cpu_we;
                  be_d    = cpu_be;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == CNT_ZERO) begin
               state_d = ST_RESP;
               if (owner_q == M_DBG) begin
                  dbg_rdata_d = bus_din;
               end else begin
                  cpu_rdata_d = bus_din;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: bus driven only in ACCESS, strobe in the last hold cycle,
   // ack to the owner in RESP
   always_comb begin
      bus_addr = 30'd0;
      bus_dout = 32'd0;
      bus_be   = 4'd0;
      bus_we   = 1'b0;
      cpu_ack  = 1'b0;
      dbg_ack  = 1'b0;
      case (state_q)
         ST_ACCESS: begin
            bus_addr = addr_q;
            bus_dout = wdata_q;
            bus_be   = be_q;
            bus_we   = we_q & (cnt_q == CNT_ZERO);
         end
         ST_RESP: begin
            cpu_ack = (owner_q == M_CPU);
            dbg_ack = (owner_q == M_DBG);
         end
         default: begin
            bus_we = 1'b0;
         end
      endcase
   end

   assign cpu_stall = cpu_req & ~cpu_ack;
   assign busy      = (state_q != ST_IDLE);
   assign owner     = owner_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: directed scenarios plus a
// randomized run checked against a transaction-timeline reference model.
module tb_dev_bus_arbiter;
   import dev_bus_arbiter_pkg::*;

   localparam int H = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_v [2];
   logic [29:0] addr_v [2];
   logic [31:0] wdata_v [2];
   logic        we_v [2];
   logic [3:0]  be_v [2];
   logic [31:0] bus_din;
   logic        cpu_ack, dbg_ack, cpu_stall, busy, owner, bus_we;
   logic [31:0] cpu_rdata, dbg_rdata, bus_dout;
   logic [29:0] bus_addr;
   logic [3:0]  bus_be;

   logic        h1_cpu_req, h1_cpu_we, h1_dbg_req, h1_dbg_we;
   logic [29:0] h1_cpu_addr, h1_dbg_addr;
   logic [31:0] h1_cpu_wdata, h1_dbg_wdata, h1_bus_din;
   logic [3:0]  h1_cpu_be, h1_dbg_be;
   logic        h1_cpu_ack, h1_dbg_ack, h1_cpu_stall, h1_busy, h1_owner, h1_bus_we;
   logic [31:0] h1_cpu_rdata, h1_dbg_rdata, h1_bus_dout;
   logic [29:0] h1_bus_addr;
   logic [3:0]  h1_bus_be;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   dev_bus_arbiter #(.HOLD_CYCLES(H), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(req_v[0]), .cpu_addr(addr_v[0]), .cpu_wdata(wdata_v[0]),
      .cpu_we(we_v[0]), .cpu_be(be_v[0]), .cpu_ack(cpu_ack),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(req_v[1]), .dbg_addr(addr_v[1]), .dbg_wdata(wdata_v[1]),
      .dbg_we(we_v[1]), .dbg_be(be_v[1]), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_be(bus_be), .bus_we(bus_we),
      .bus_din(bus_din), .busy(busy), .owner(owner)
   );

   dev_bus_arbiter #(.HOLD_CYCLES(1), .CNT_W(4)) u_dut_h1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(h1_cpu_req), .cpu_addr(h1_cpu_addr), .cpu_wdata(h1_cpu_wdata),
      .cpu_we(h1_cpu_we), .cpu_be(h1_cpu_be), .cpu_ack(h1_cpu_ack),
      .cpu_rdata(h1_cpu_rdata), .cpu_stall(h1_cpu_stall),
      .dbg_req(h1_dbg_req), .dbg_addr(h1_dbg_addr), .dbg_wdata(h1_dbg_wdata),
      .dbg_we(h1_dbg_we), .dbg_be(h1_dbg_be), .dbg_ack(h1_dbg_ack), .dbg_rdata(h1_dbg_rdata),
      .bus_addr(h1_bus_addr), .bus_dout(h1_bus_dout), .bus_be(h1_bus_be), .bus_we(h1_bus_we),
      .bus_din(h1_bus_din), .busy(h1_busy), .owner(h1_owner)
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      for (int m = 0; m < 2; m++) begin
         req_v[m] = 1'b0; addr_v[m] = 30'd0; wdata_v[m] = 32'd0;
         we_v[m] = 1'b0; be_v[m] = 4'd0;
      end
      bus_din = 32'd0;
      h1_cpu_req = 1'b0; h1_cpu_we = 1'b0; h1_cpu_addr = 30'd0; h1_cpu_wdata = 32'd0;
      h1_cpu_be = 4'd0; h1_dbg_req = 1'b0; h1_dbg_we = 1'b0; h1_dbg_addr = 30'd0;
      h1_dbg_wdata = 32'd0; h1_dbg_be = 4'd0; h1_bus_din = 32'd0;
   endtask

   task automatic test_reset;
      logic [66:0] bus_all;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      bus_all = {bus_addr, bus_dout, bus_be, bus_we};
      total_cnt++;
      if (bus_all !== 67'd0) $display("FAIL reset_bus: got %h want 0", bus_all);
      else pass_cnt++;
      total_cnt++;
      if ({busy, owner, cpu_ack, dbg_ack} !== 4'b0100)
         $display("FAIL reset_ctl: got %b want 0100", {busy, owner, cpu_ack, dbg_ack});
      else pass_cnt++;
      total_cnt++;
      if ({cpu_rdata, dbg_rdata} !== 64'd0)
         $display("FAIL reset_rdata: got %h want 0", {cpu_rdata, dbg_rdata});
      else pass_cnt++;
      total_cnt++;
      if (h1_owner !== 1'b1) $display("FAIL reset_h1_owner: got %b want 1", h1_owner);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_cycle;
      h1_cpu_req = 1'b1; h1_cpu_addr = {DEV_SWITCH_BASE, 2'b00}; h1_cpu_we = 1'b0;
      h1_cpu_be = 4'hF; h1_bus_din = 32'h0000_00A5;
      #1;
      total_cnt++;
      if (h1_cpu_stall !== 1'b1) $display("FAIL h1_stall_idle: got %b want 1", h1_cpu_stall);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({h1_bus_addr, h1_cpu_ack, h1_cpu_stall, h1_bus_we} !== {30'h1FC4, 3'b010})
         $display("FAIL h1_access: got %h/%b want 1fc4/010", h1_bus_addr,
                  {h1_cpu_ack, h1_cpu_stall, h1_bus_we});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({h1_bus_addr, h1_cpu_ack, h1_cpu_stall} !== {30'd0, 2'b10})
         $display("FAIL h1_resp: got %h/%b want 0/10", h1_bus_addr, {h1_cpu_ack, h1_cpu_stall});
      else pass_cnt++;
      total_cnt++;
      if (h1_cpu_rdata !== 32'h0000_00A5) $display("FAIL h1_rdata: got %h want a5", h1_cpu_rdata);
      else pass_cnt++;
      h1_cpu_req = 1'b0;
      tick();
      total_cnt++;
      if ({h1_cpu_ack, h1_busy} !== 2'b00) $display("FAIL h1_after: got %b want 00", {h1_cpu_ack, h1_busy});
      else pass_cnt++;
   endtask

   task automatic test_write_hold;
      int we_pulses = 0;
      req_v[0] = 1'b1; addr_v[0] = {DEV_COUNTER_BASE, 2'b01}; wdata_v[0] = 32'h0000_00FF;
      we_v[0] = 1'b1; be_v[0] = 4'hF; bus_din = 32'h1234_5678;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus_we === 1'b1) we_pulses++;
         total_cnt++;
         if (bus_addr !== ((k < H) ? addr_v[0] : 30'd0))
            $display("FAIL wr_addr k=%0d: got %h want %h", k, bus_addr, (k < H) ? addr_v[0] : 30'd0);
         else pass_cnt++;
         total_cnt++;
         if ({bus_we, cpu_ack} !== {(k == H - 1), (k == H)})
            $display("FAIL wr_strobe_ack k=%0d: got %b want %b", k, {bus_we, cpu_ack},
                     {(k == H - 1), (k == H)});
         else pass_cnt++;
         if (k == H) req_v[0] = 1'b0;
      end
      total_cnt++;
      if (we_pulses != 1) $display("FAIL wr_pulses: got %0d want 1", we_pulses);
      else pass_cnt++;
      total_cnt++;
      if (cpu_rdata !== 32'h1234_5678) $display("FAIL wr_rdata: got %h want 12345678", cpu_rdata);
      else pass_cnt++;
   endtask

   task automatic test_tie_alternate;
      int w;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_v[0] = 1'b1; addr_v[0] = 30'h100; req_v[1] = 1'b1; addr_v[1] = 30'h200;
      for (int i = 0; i < 4; i++) begin
         w = i % 2;
         tick();
         total_cnt++;
         if ({owner, bus_addr} !== {w[0], addr_v[w]})
            $display("FAIL tie_grant i=%0d: got %b/%h want %b/%h", i, owner, bus_addr, w[0], addr_v[w]);
         else pass_cnt++;
         tick(); tick(); tick();
         total_cnt++;
         if ({cpu_ack, dbg_ack} !== {(w == 0), (w == 1)})
            $display("FAIL tie_ack i=%0d: got %b want %b", i, {cpu_ack, dbg_ack}, {(w == 0), (w == 1)});
         else pass_cnt++;
         addr_v[w] = addr_v[w] + 30'd1;
         tick();
      end
      req_v[0] = 1'b0; req_v[1] = 1'b0;
   endtask

   task automatic test_dbg_then_cpu;
      req_v[1] = 1'b1; addr_v[1] = 30'h2A0; we_v[1] = 1'b0;
      tick();
      total_cnt++;
      if ({owner, bus_addr} !== {1'b1, 30'h2A0})
         $display("FAIL dc_dbg_grant: got %b/%h want 1/2a0", owner, bus_addr);
      else pass_cnt++;
      req_v[0] = 1'b1; addr_v[0] = 30'h1C0; we_v[0] = 1'b0;
      for (int k = 1; k < H; k++) begin
         tick();
         total_cnt++;
         if ({bus_addr, cpu_stall} !== {30'h2A0, 1'b1})
            $display("FAIL dc_hold k=%0d: got %h/%b want 2a0/1", k, bus_addr, cpu_stall);
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if ({dbg_ack, cpu_ack, cpu_stall} !== 3'b101)
         $display("FAIL dc_dbg_resp: got %b want 101", {dbg_ack, cpu_ack, cpu_stall});
      else pass_cnt++;
      req_v[1] = 1'b0;
      tick();
      total_cnt++;
      if ({busy, cpu_stall} !== 2'b01) $display("FAIL dc_idle: got %b want 01", {busy, cpu_stall});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({owner, bus_addr, cpu_stall} !== {1'b0, 30'h1C0, 1'b1})
         $display("FAIL dc_cpu_grant: got %b/%h/%b want 0/1c0/1", owner, bus_addr, cpu_stall);
      else pass_cnt++;
      for (int k = 0; k < H; k++) tick();
      total_cnt++;
      if ({cpu_ack, cpu_stall} !== 2'b10) $display("FAIL dc_cpu_resp: got %b want 10", {cpu_ack, cpu_stall});
      else pass_cnt++;
      req_v[0] = 1'b0;
      tick();
   endtask

   task automatic test_drop_req;
      int acks = 0;
      req_v[0] = 1'b1; addr_v[0] = 30'h1FC8; we_v[0] = 1'b0; bus_din = 32'hCAFE_0001;
      tick();
      req_v[0] = 1'b0;
      for (int k = 1; k < 6; k++) begin
         tick();
         if (cpu_ack === 1'b1) acks++;
         total_cnt++;
         if (cpu_ack !== (k == H)) $display("FAIL drop_ack k=%0d: got %b want %b", k, cpu_ack, (k == H));
         else pass_cnt++;
      end
      total_cnt++;
      if (acks != 1) $display("FAIL drop_ack_count: got %0d want 1", acks);
      else pass_cnt++;
      total_cnt++;
      if (cpu_rdata !== 32'hCAFE_0001) $display("FAIL drop_rdata: got %h want cafe0001", cpu_rdata);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      int we_pulses = 0;
      req_v[0] = 1'b1; addr_v[0] = 30'h1FC0; wdata_v[0] = 32'h5A5A_0003;
      we_v[0] = 1'b1; be_v[0] = 4'hF;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({bus_addr, bus_dout, bus_be, bus_we, busy, owner, cpu_ack} !== {69'd0, 1'b1, 1'b0})
         $display("FAIL rstmid_async: got %h/%h/%h/%b%b%b%b want all 0 owner 1", bus_addr, bus_dout,
                  bus_be, bus_we, busy, owner, cpu_ack);
      else pass_cnt++;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bus_we !== 1'b0 || cpu_ack !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL rstmid_hold: got %0d strobe/ack cycles want 0", bad);
      else pass_cnt++;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus_we === 1'b1) we_pulses++;
         total_cnt++;
         if (cpu_ack !== (k == H)) $display("FAIL rstmid_ack k=%0d: got %b want %b", k, cpu_ack, (k == H));
         else pass_cnt++;
         if (k == H) req_v[0] = 1'b0;
      end
      total_cnt++;
      if (we_pulses != 1) $display("FAIL rstmid_pulses: got %0d want 1", we_pulses);
      else pass_cnt++;
   endtask

   task automatic test_random;
      int e = 0;
      int g = 0;
      int k;
      bit act = 1'b0;
      bit own = 1'b1;
      bit win = 1'b0;
      logic [29:0] m_a = 30'd0;
      logic [31:0] m_wd = 32'd0;
      logic m_we = 1'b0;
      logic [3:0] m_be = 4'd0;
      logic [31:0] m_rd [2];
      bit pend [2];
      bit exp_ack [2];
      bit acc;
      logic [71:0] got_v, exp_v;
      m_rd[0] = 32'd0; m_rd[1] = 32'd0; pend[0] = 1'b0; pend[1] = 1'b0;
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 600; n++) begin
         @(posedge clk);
         e++;
         // timeline: grant at edge g, bus cycles after g..g+H-1, ack after g+H,
         // next arbitration at edge g+H+2
         if (act && e - g == H) m_rd[win] = bus_din;
         if (!act || e - g >= H + 2) begin
            act = 1'b0;
            if (req_v[0] || req_v[1]) begin
               win = (req_v[0] && req_v[1]) ? !own : req_v[1];
               own = win; g = e; act = 1'b1;
               m_a = addr_v[win]; m_wd = wdata_v[win]; m_we = we_v[win]; m_be = be_v[win];
            end
         end
         @(negedge clk);
         k = e - g;
         acc = act && (k < H);
         exp_ack[0] = act && (k == H) && (win == 1'b0);
         exp_ack[1] = act && (k == H) && (win == 1'b1);
         exp_v = {acc ? m_a : 30'd0, acc ? m_wd : 32'd0, acc ? m_be : 4'd0,
                  acc && (k == H - 1) && m_we, act && (k <= H), own,
                  exp_ack[0], exp_ack[1], req_v[0] & !exp_ack[0]};
         got_v = {bus_addr, bus_dout, bus_be, bus_we, busy, owner, cpu_ack, dbg_ack, cpu_stall};
         total_cnt++;
         if (got_v !== exp_v) $display("FAIL rand_outputs n=%0d: got %h want %h", n, got_v, exp_v);
         else pass_cnt++;
         total_cnt++;
         if ({cpu_rdata, dbg_rdata} !== {m_rd[0], m_rd[1]})
            $display("FAIL rand_rdata n=%0d: got %h want %h", n, {cpu_rdata, dbg_rdata}, {m_rd[0], m_rd[1]});
         else pass_cnt++;
         for (int m = 0; m < 2; m++) begin
            if (pend[m] && exp_ack[m]) pend[m] = 1'b0;
            if (!pend[m]) begin
               if ($urandom_range(0, 2) == 0) begin
                  pend[m] = 1'b1; req_v[m] = 1'b1;
                  addr_v[m] = ($urandom_range(0, 1) == 1) ? {DEV_DISPLAY_BASE, 2'($urandom)} : 30'($urandom);
                  wdata_v[m] = $urandom; we_v[m] = 1'($urandom); be_v[m] = 4'($urandom);
               end else begin
                  req_v[m] = 1'b0;
               end
            end else if (act && (win == m[0]) && (k < H) && $urandom_range(0, 7) == 0) begin
               req_v[m] = 1'b0;
            end
         end
         bus_din = $urandom;
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_cycle();
      test_write_hold();
      test_tie_alternate();
      test_dbg_then_cpu();
      test_drop_req();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
